// File: rtl/prng_share_arb.sv
// Shared 32-bit XNOR LFSR random source with seed load, warm-up and a
// round-robin arbiter returning one SIZE-bit value per grant, 1 cycle later.
module prng_share_arb #(
    parameter int NREQ   = 4,
    parameter int SIZE   = 8,
    parameter int WARMUP = 4
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic [31:0]     seed_i,
    input  logic            reseed_i,
    input  logic [31:0]     reseed_data_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            rnd_valid_o,
    output logic [SIZE-1:0] rnd_o,
    output logic            busy_o
);

    localparam int         PTR_W      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] WARMUP_CNT = 8'(WARMUP);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_lfsr;
    logic [31:0]       w_lfsr_nxt;
    logic [31:0]       w_lfsr_step;
    logic [7:0]        r_warm_cnt;
    logic [7:0]        w_warm_cnt_nxt;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [PTR_W-1:0]  w_rr_ptr_nxt;
    logic [PTR_W-1:0]  w_ptr_inc;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   w_gnt_nxt;
    logic [SIZE-1:0]   r_rnd;
    logic [SIZE-1:0]   w_rnd_nxt;
    logic              w_found;
    logic [PTR_W-1:0]  w_winner;
    logic [PTR_W-1:0]  w_idx_p;
    int                w_idx;

    assign w_lfsr_step = {r_lfsr[30:0], ~(r_lfsr[31] ^ r_lfsr[23] ^ r_lfsr[15] ^ r_lfsr[7])};

    // Cyclic search from r_rr_ptr: scanning offsets high-to-low lets the
    // smallest offset overwrite the others, so no early exit is needed.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        w_idx_p  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            w_idx_p = PTR_W'(w_idx);
            if (req_i[w_idx_p]) begin
                w_found  = 1'b1;
                w_winner = w_idx_p;
            end
        end
    end

    assign w_ptr_inc = (w_winner == PTR_W'(NREQ - 1)) ? '0 : w_winner + PTR_W'(1);

    // Handshake: a requester holds req_i high until it sees its gnt_o bit,
    // which arrives the cycle after the request was sampled together with
    // rnd_o; a request still high in that cycle counts as a fresh request.
    always_comb begin
        w_state_nxt    = r_state;
        w_lfsr_nxt     = r_lfsr;
        w_warm_cnt_nxt = r_warm_cnt;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_gnt_nxt      = '0;
        w_rnd_nxt      = r_rnd;
        if (reseed_i) begin
            // Reseed wins over any grant that would have happened this cycle.
            w_lfsr_nxt  = reseed_data_i;
            w_state_nxt = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    w_warm_cnt_nxt = WARMUP_CNT;
                    w_state_nxt    = ST_WARM;
                end
                ST_WARM: begin
                    if (r_warm_cnt == 8'd0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_lfsr_nxt     = w_lfsr_step;
                        w_warm_cnt_nxt = r_warm_cnt - 8'd1;
                    end
                end
                ST_RUN: begin
                    if (w_found) begin
                        w_gnt_nxt[w_winner] = 1'b1;
                        w_rnd_nxt           = r_lfsr[SIZE-1:0];
                        w_lfsr_nxt          = w_lfsr_step;
                        w_rr_ptr_nxt        = w_ptr_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state    <= ST_WARM;
            r_lfsr     <= seed_i;
            r_warm_cnt <= WARMUP_CNT;
            r_rr_ptr   <= '0;
            r_gnt      <= '0;
            r_rnd      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_warm_cnt <= w_warm_cnt_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_gnt      <= w_gnt_nxt;
            r_rnd      <= w_rnd_nxt;
        end
    end

    assign gnt_o       = r_gnt;
    assign rnd_valid_o = |r_gnt;
    assign rnd_o       = r_rnd;
    assign busy_o      = (r_state != ST_RUN);

endmodule

// File: tb/tb_prng_share_arb.sv
// Bench for prng_share_arb: directed test-plan steps followed by random
// requests/reseeds, checked against a queue-based behavioural model.
module tb_prng_share_arb;

    localparam int NREQ   = 4;
    localparam int SIZE   = 8;
    localparam int WARMUP = 4;

    logic            clk = 1'b0;
    logic            rst_l = 1'b1;
    logic [31:0]     seed = '0;
    logic            reseed = 1'b0;
    logic [31:0]     reseed_data = '0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic            rnd_valid;
    logic [SIZE-1:0] rnd;
    logic            busy;

    // Second instance with no warm-up steps.
    logic            rst0_l = 1'b1;
    logic [31:0]     seed0 = 32'h1234_5678;
    logic            reseed0 = 1'b0;
    logic [31:0]     reseed_data0 = '0;
    logic [NREQ-1:0] req0 = 4'b0001;
    logic [NREQ-1:0] gnt0;
    logic            rnd_valid0;
    logic [SIZE-1:0] rnd0;
    logic            busy0;

    int checks = 0;
    int errors = 0;

    // Reference model: warm-up is a queue of per-cycle "step or not" actions.
    logic [31:0]     m_lfsr;
    int              m_ptr;
    bit              m_warm_q[$];
    logic [NREQ-1:0] m_gnt;
    logic [SIZE-1:0] m_rnd;

    logic [7:0]      tp1_tbl[6] = '{8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE};
    logic [3:0]      tp2_tbl[5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [7:0]      pend;

    prng_share_arb #(.NREQ(NREQ), .SIZE(SIZE), .WARMUP(WARMUP)) u_dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .seed_i       (seed),
        .reseed_i     (reseed),
        .reseed_data_i(reseed_data),
        .req_i        (req),
        .gnt_o        (gnt),
        .rnd_valid_o  (rnd_valid),
        .rnd_o        (rnd),
        .busy_o       (busy)
    );

    prng_share_arb #(.NREQ(NREQ), .SIZE(SIZE), .WARMUP(0)) u_dut0 (
        .clk          (clk),
        .rst_l        (rst0_l),
        .seed_i       (seed0),
        .reseed_i     (reseed0),
        .reseed_data_i(reseed_data0),
        .req_i        (req0),
        .gnt_o        (gnt0),
        .rnd_valid_o  (rnd_valid0),
        .rnd_o        (rnd0),
        .busy_o       (busy0)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return {l[30:0], ~(l[31] ^ l[23] ^ l[15] ^ l[7])};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_warm(input bit with_load);
        m_warm_q.delete();
        if (with_load) m_warm_q.push_back(1'b0);
        repeat (WARMUP) m_warm_q.push_back(1'b1);
        m_warm_q.push_back(1'b0);
    endtask

    // Predict the effect of the coming edge, then compare all outputs after it.
    task automatic tick();
        bit a;
        int win;
        m_gnt = '0;
        if (reseed) begin
            m_lfsr = reseed_data;
            fill_warm(1'b1);
        end else if (m_warm_q.size() != 0) begin
            a = m_warm_q.pop_front();
            if (a) m_lfsr = lfsr_next(m_lfsr);
        end else if (req != '0) begin
            win = -1;
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            end
            m_gnt[win] = 1'b1;
            m_ptr      = (win + 1) % NREQ;
            m_rnd      = m_lfsr[SIZE-1:0];
            m_lfsr     = lfsr_next(m_lfsr);
        end
        @(posedge clk);
        #1;
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("rnd_valid", 32'(rnd_valid), 32'(m_gnt != '0));
        chk("rnd", 32'(rnd), 32'(m_rnd));
        chk("busy", 32'(busy), 32'(m_warm_q.size() != 0));
    endtask

    task automatic do_reset(input logic [31:0] s);
        seed  = s;
        rst_l = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_valid", 32'(rnd_valid), 32'd0);
        chk("rst_rnd", 32'(rnd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        m_lfsr = s;
        m_ptr  = 0;
        m_gnt  = '0;
        m_rnd  = '0;
        fill_warm(1'b0);
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        rst0_l = 1'b0;
        req    = 4'b0001;
        do_reset(32'h0);

        // Warm-up: busy for 5 cycles, then the known sequence from seed 0.
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("tp1_busy", 32'(busy), (k < 4) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("tp1_rnd", 32'(rnd), 32'(tp1_tbl[k]));
            chk("tp1_gnt", 32'(gnt), 32'd1);
        end

        // All requesting: grants rotate starting after requester 0.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("tp2_gnt", 32'(gnt), 32'(tp2_tbl[k]));
        end

        // Idle must not step the LFSR.
        req  = '0;
        pend = m_lfsr[7:0];
        for (int k = 0; k < 10; k++) tick();
        req = 4'b0100;
        tick();
        chk("tp3_first_rnd", 32'(rnd), 32'(pend));
        chk("tp3_gnt", 32'(gnt), 32'b0100);

        // Reseed beats a pending request; 6 busy cycles then 0x0F.
        req         = 4'b0010;
        reseed      = 1'b1;
        reseed_data = 32'h0;
        tick();
        chk("tp4_nognt", 32'(gnt), 32'd0);
        chk("tp4_busy0", 32'(busy), 32'd1);
        reseed = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("tp4_busy", 32'(busy), 32'd1);
        end
        tick();
        chk("tp4_run", 32'(busy), 32'd0);
        tick();
        chk("tp4_gnt", 32'(gnt), 32'b0010);
        chk("tp4_rnd", 32'(rnd), 32'h0F);

        // Reset in the middle of a grant; pointer returns to 0.
        req = 4'b0100;
        tick();
        chk("tp5_gnt", 32'(gnt), 32'b0100);
        #2;
        do_reset($urandom);
        req = 4'b1111;
        for (int k = 0; k < 6; k++) tick();
        chk("tp5_first", 32'(gnt), 32'b0001);

        // Random traffic with occasional reseeds and one mid-run reset.
        for (int n = 0; n < 400; n++) begin
            reseed      = ($urandom_range(0, 19) == 0);
            reseed_data = $urandom;
            if ($urandom_range(0, 3) == 0)
                req = 4'($urandom_range(0, 15));
            else
                req = (req & ~m_gnt) | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            if (n == 200) begin
                reseed = 1'b0;
                #2;
                do_reset($urandom);
            end
            tick();
        end
        reseed = 1'b0;

        // WARMUP=0 instance: one WARM cycle, first value is the seed's low byte.
        @(negedge clk);
        rst0_l = 1'b1;
        #1;
        chk("w0_busy_rst", 32'(busy0), 32'd1);
        @(posedge clk);
        #1;
        chk("w0_busy_run", 32'(busy0), 32'd0);
        chk("w0_nognt", 32'(gnt0), 32'd0);
        @(posedge clk);
        #1;
        chk("w0_gnt", 32'(gnt0), 32'd1);
        chk("w0_valid", 32'(rnd_valid0), 32'd1);
        chk("w0_rnd", 32'(rnd0), 32'h78);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prng_share_arb.md
Name: prng_share_arb

Overview:
- Shares one 32-bit XNOR LFSR random source among NREQ requesters, e.g. I-cache random way replacement, BTB victim select and the MBPTA timing randomizers.
- Sequences the LFSR through seed load, a warm-up phase and run.
- Arbitrates round-robin between requesters and returns one SIZE-bit random value per grant with a fixed 1-cycle latency.
- Supports run-time reseeding from CSR logic.

Parameters:
- NREQ, 4, number of requesters (2..8)
- SIZE, 8, width of each returned random value (1..32)
- WARMUP, 4, LFSR steps discarded after reset or reseed (0..255)

Ports:
- clk  input  1  core clock
- rst_l  input  1  asynchronous active-low reset
- seed_i  input  32  seed loaded into LFSR during reset
- reseed_i  input  1  single-cycle reseed request
- reseed_data_i  input  32  seed used when reseed_i=1
- req_i  input  NREQ  per-requester request; level, held until granted
- gnt_o  output  NREQ  one-hot registered grant
- rnd_valid_o  output  1  rnd_o valid; equals |gnt_o
- rnd_o  output  SIZE  random value for the granted requester
- busy_o  output  1  1 while in LOAD/WARM (no grants possible)

Behaviour:
- LFSR step (identical to existing PRNG): newbit = ~(l[31]^l[23]^l[15]^l[7]); next = {l[30:0], newbit}. All-ones is the lock-up state; all-zero is legal.
- Reset (rst_l=0, async):
  - lfsr<=seed_i, state<=WARM, warm_cnt<=WARMUP, rr_ptr<=0.
  - gnt_o=0, rnd_valid_o=0, rnd_o=0, busy_o=1.
  - seed_i must be stable while rst_l is low.
- FSM states: LOAD, WARM, RUN.
  - WARM: LFSR steps every cycle; warm_cnt decrements. When warm_cnt==0 at cycle start, no step and the state becomes RUN that cycle. WARMUP=0 therefore costs exactly 1 WARM cycle.
  - RUN:
    - If any req_i bit is set, grant the first set bit at or after rr_ptr (cyclic search).
    - Next cycle: gnt_o one-hot for the winner, rnd_o=lfsr[SIZE-1:0] (value before the step), rnd_valid_o=1.
    - On the same edge: LFSR steps once and rr_ptr <= winner+1 (mod NREQ).
    - With no request: gnt_o=0, rnd_valid_o=0, rnd_o holds its last value, LFSR does not step.
  - reseed_i=1 in any state: next cycle lfsr<=reseed_data_i, state<=LOAD, gnt_o=0. Reseed has priority over a grant in the same cycle, and that request is not granted.
  - LOAD: 1 cycle, no step; then warm_cnt<=WARMUP and state<=WARM.
  - reseed_i during LOAD/WARM restarts the sequence from LOAD with the new data.
- Throughput: at most one grant per cycle; back-to-back grants allowed to the same or different requesters.
- Fairness: a requester continuously asserting req_i is granted within NREQ RUN cycles.
- Requester handshake: sees gnt_o[i]=1 one cycle after sampling and drops or re-asserts req_i that cycle. A request still high in the grant cycle is treated as a new request.
- busy_o=1 in LOAD and WARM, 0 in RUN.

Test Plan:
- Reset with seed_i=0, WARMUP=4, SIZE=8, req_i=0001 held → busy_o low after 5 cycles; successive rnd_o = 0x0F,0x1F,0x3F,0x7F,0xFF,0xFE, one per cycle, gnt_o=0001 each time.
- RUN, req_i=1111 held continuously → gnt_o sequence 0001,0010,0100,1000,0001; LFSR steps exactly once per grant.
- RUN, req_i=0 for 10 cycles then req_i=0100 → no gnt_o and no LFSR step during idle; first rnd_o equals the value pending before the idle period.
- reseed_i with reseed_data_i=0 while req_i=0010 → no grant that cycle; busy_o=1 for LOAD+WARM (6 cycles); next rnd_o=0x0F.
- rst_l asserted mid-grant (gnt_o=0100) → gnt_o, rnd_valid_o and rnd_o go to 0 asynchronously; after release rr_ptr=0, so with req_i=1111 the first grant is 0001.
- WARMUP=0, seed 0x12345678 → RUN after exactly 1 WARM cycle; first rnd_o = 0x78.
